// File: rtl/fnd_scan_controller.sv
// ============================================================================
// fnd_scan_controller
// ----------------------------------------------------------------------------
// Drives a 4-digit multiplexed common-anode seven-segment (FND) display from
// an unsigned binary value.
//
// Three cooperating blocks:
//   1. Binary-to-BCD converter: an iterative shift-add-3 (double dabble) FSM
//      that processes one bit per clock. The displayed BCD register is only
//      written once a conversion has finished, so a partial result is never
//      visible on the display.
//   2. Scan-rate divider: counts 0..SCAN_DIV-1. Its terminal count advances
//      the digit index 0 -> 1 -> 2 -> 3 -> 0.
//   3. Output stage: registered digit enables and segment font. There is one
//      clock of latency from the digit index, the displayed register and i_en.
//
// Parameters:
//   SCAN_DIV  clocks per digit slot (>= 2)
//   VALUE_W   width of i_value
//
// Ports:
//   i_clk       system clock
//   i_reset_n   asynchronous active-low reset
//   i_en        display enable; 0 blanks all digits. The divider and the
//               converter keep running while blanked.
//   i_value     unsigned binary value to display
//   o_busy      high while a BCD conversion is in progress
//   o_digit     digit enables, one-hot active-low; bit0 = ones digit
//   o_fndfont   segments active-low, {dp,g,f,e,d,c,b,a}
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  when defined, the thousands, hundreds and tens
//                          digits are blanked while they and every higher
//                          digit are zero. The ones digit is always shown,
//                          and overflow dashes are unaffected.
// ============================================================================
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100000,
    parameter int VALUE_W  = 14
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_en,
    input  logic [VALUE_W-1:0] i_value,
    output logic               o_busy,
    output logic [3:0]         o_digit,
    output logic [7:0]         o_fndfont
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] FONT_DASH  = 8'hBF;

    // ------------------------------------------------------------------------
    // Segment font for one BCD nibble. Codes above 9 cannot occur from a
    // correct conversion, but they still map to blank rather than to garbage.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg_font(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = FONT_BLANK;
        endcase
        return f;
    endfunction

    // ------------------------------------------------------------------------
    // Scan-rate divider and digit index
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic [1:0]       index_reg;
    logic [1:0]       index_next;
    logic             scan_tick;

    assign scan_tick = (div_reg == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        div_next   = div_reg + DIV_W'(1);
        index_next = index_reg;
        if (scan_tick) begin
            div_next   = '0;
            index_next = index_reg + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_reg   <= '0;
            index_reg <= '0;
        end else begin
            div_reg   <= div_next;
            index_reg <= index_next;
        end
    end

    // ------------------------------------------------------------------------
    // Binary-to-BCD converter
    // ------------------------------------------------------------------------
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [VALUE_W-1:0] value_reg;      // value being (or last) converted
    logic [VALUE_W-1:0] value_next;
    logic [15:0]        bcd_reg;        // working BCD accumulator
    logic [15:0]        bcd_next;
    logic [VALUE_W-1:0] bin_reg;        // binary bits still to shift in
    logic [VALUE_W-1:0] bin_next;
    logic [CNT_W-1:0]   iter_reg;       // iterations remaining
    logic [CNT_W-1:0]   iter_next;
    logic               busy_reg;
    logic               busy_next;
    logic [15:0]        disp_reg;       // BCD shown on the display
    logic [15:0]        disp_next;
    logic               overflow_reg;
    logic               overflow_next;

    // Add-3 correction applied to every nibble before the shift.
    logic [15:0] bcd_adj;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            always_comb begin
                if (bcd_reg[gi*4 +: 4] >= 4'd5) begin
                    bcd_adj[gi*4 +: 4] = bcd_reg[gi*4 +: 4] + 4'd3;
                end else begin
                    bcd_adj[gi*4 +: 4] = bcd_reg[gi*4 +: 4];
                end
            end
        end
    endgenerate

    // The bit shifted out of the thousands digit would form a fifth digit.
    // Values large enough to need it are flagged as overflow instead, so the
    // bit is intentionally dropped.
    logic bcd_spill_unused;
    assign bcd_spill_unused = bcd_adj[15];

    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        bcd_next      = bcd_reg;
        bin_next      = bin_reg;
        iter_next     = iter_reg;
        busy_next     = busy_reg;
        disp_next     = disp_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            ST_IDLE: begin
                // Changes that arrive while busy are not queued. The input is
                // re-compared here, so only the latest stable value is converted.
                if (i_value != value_reg) begin
                    value_next = i_value;
                    bcd_next   = '0;
                    bin_next   = i_value;
                    iter_next  = CNT_W'(VALUE_W);
                    busy_next  = 1'b1;
                    state_next = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                bcd_next  = {bcd_adj[14:0], bin_reg[VALUE_W-1]};
                bin_next  = bin_reg << 1;
                iter_next = iter_reg - CNT_W'(1);
                if (iter_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // Single atomic update of the displayed digits.
                disp_next     = bcd_reg;
                overflow_next = (32'(value_reg) > 32'd9999);
                busy_next     = 1'b0;
                state_next    = ST_IDLE;
            end

            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            value_reg    <= '0;
            bcd_reg      <= '0;
            bin_reg      <= '0;
            iter_reg     <= '0;
            busy_reg     <= 1'b0;
            disp_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            bcd_reg      <= bcd_next;
            bin_reg      <= bin_next;
            iter_reg     <= iter_next;
            busy_reg     <= busy_next;
            disp_reg     <= disp_next;
            overflow_reg <= overflow_next;
        end
    end

    assign o_busy = busy_reg;

    // ------------------------------------------------------------------------
    // Digit selection and optional leading-zero suppression
    // ------------------------------------------------------------------------
    logic [3:0] sel_nibble;
    logic       blank_digit;

    assign sel_nibble = disp_reg[{index_reg, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i] is set when digit i and every higher digit are zero.
    logic [3:0] zero_from;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero_from
            if (gi == 3) begin : g_top
                assign zero_from[gi] = (disp_reg[gi*4 +: 4] == 4'd0);
            end else begin : g_lower
                assign zero_from[gi] = (disp_reg[gi*4 +: 4] == 4'd0) && zero_from[gi+1];
            end
        end
    endgenerate

    // The ones digit is never blanked, so a value of zero still shows "0".
    assign blank_digit = (index_reg != 2'd0) && zero_from[index_reg];
`else
    assign blank_digit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------------
    logic [3:0] digit_reg;
    logic [3:0] digit_next;
    logic [7:0] font_reg;
    logic [7:0] font_next;

    always_comb begin
        digit_next = 4'b1111;
        font_next  = FONT_BLANK;
        if (i_en) begin
            digit_next = ~(4'b0001 << index_reg);
            if (overflow_reg) begin
                font_next = FONT_DASH;
            end else if (blank_digit) begin
                font_next = FONT_BLANK;
            end else begin
                font_next = seg_font(sel_nibble);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit_reg <= 4'b1111;
            font_reg  <= FONT_BLANK;
        end else begin
            digit_reg <= digit_next;
            font_reg  <= font_next;
        end
    end

    assign o_digit   = digit_reg;
    assign o_fndfont = font_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ============================================================================
// tb_fnd_scan_controller
// ----------------------------------------------------------------------------
// Directed bench for fnd_scan_controller with SCAN_DIV=4 and VALUE_W=14.
//
// Each value driven onto i_value is pushed onto a scoreboard queue. When a
// conversion finishes (o_busy falls), the queue is popped and the popped value
// becomes the expected display content. The segment patterns are derived from
// the decimal digits of that value. Outputs are sampled on the falling edge.
// ============================================================================
module tb_fnd_scan_controller;

    localparam int SCAN_DIV = 4;
    localparam int VALUE_W  = 14;

    logic               clk     = 1'b0;
    logic               reset_n = 1'b0;
    logic               en      = 1'b0;
    logic [VALUE_W-1:0] value   = '0;
    logic               busy;
    logic [3:0]         digit;
    logic [7:0]         fndfont;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int shown  = 0;   // value the display is expected to show right now

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .SCAN_DIV (SCAN_DIV),
        .VALUE_W  (VALUE_W)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_en      (en),
        .i_value   (value),
        .o_busy    (busy),
        .o_digit   (digit),
        .o_fndfont (fndfont)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] digit_font(input int d);
        logic [7:0] f;
        case (d)
            0: f = 8'hC0;
            1: f = 8'hF9;
            2: f = 8'hA4;
            3: f = 8'hB0;
            4: f = 8'h99;
            5: f = 8'h92;
            6: f = 8'h82;
            7: f = 8'hF8;
            8: f = 8'h80;
            9: f = 8'h90;
            default: f = 8'hFF;
        endcase
        return f;
    endfunction

    // Expected segments for decimal position idx (0 = ones) of value v.
    function automatic logic [7:0] font_of(input int v, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (v > 9999) return 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 8'hFF;
`endif
        return digit_font((v / p) % 10);
    endfunction

    function automatic int idx_of(input logic [3:0] dg);
        int r;
        case (dg)
            4'b1110: r = 0;
            4'b1101: r = 1;
            4'b1011: r = 2;
            4'b0111: r = 3;
            default: r = -1;
        endcase
        return r;
    endfunction

    // Check the currently driven digit against the expected display.
    task automatic check_now(input string tag);
        int idx;
        idx = idx_of(digit);
        chk({tag, "_onehot"}, (idx >= 0), 1);
        if (idx >= 0) chk({tag, "_font"}, fndfont, font_of(shown, idx));
        $display("tb: %s digit=%b font=%h busy=%b shown=%0d", tag, digit, fndfont, busy, shown);
    endtask

    // Follow one conversion window. n0 counts busy samples already seen
    // before the current sample. The task returns on the first sample that
    // shows the newly converted value.
    task automatic run_conversion(input int n0, input string tag);
        int n;
        int guard;
        n = n0;
        guard = 0;
        while (busy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_busy_rise"}, (guard < 50), 1);
        while (busy === 1'b1 && n < 100) begin
            check_now({tag, "_hold"});
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, n, 15);
        check_now({tag, "_old"});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            shown = exp_q.pop_front();
        end
        check_now({tag, "_new"});
    endtask

    // Align to the start of the ones-digit slot, then check one full
    // 16-clock scan. The task ends at the first sample of the next scan.
    task automatic check_scan(input string tag);
        logic [3:0] prev;
        logic [3:0] e;
        int guard;
        guard = 0;
        prev = digit;
        @(negedge clk);
        while (!(digit == 4'b1110 && prev != 4'b1110) && guard < 40) begin
            prev = digit;
            @(negedge clk);
            guard++;
        end
        chk({tag, "_align"}, (guard < 40), 1);
        for (int k = 0; k < 16; k++) begin
            e = 4'b0001 << (k / 4);
            e = ~e;
            chk({tag, "_digit"}, digit, e);
            chk({tag, "_font"}, fndfont, font_of(shown, k / 4));
            if (k == 0) chk({tag, "_busy"}, busy, 0);
            $display("tb: %s k=%0d digit=%b font=%h", tag, k, digit, fndfont);
            @(negedge clk);
        end
    endtask

    initial begin
        int guard;

        // 1. reset, then scan of 0
        en = 1'b1;
        value = '0;
        repeat (2) @(negedge clk);
        chk("rst_digit", digit, 4'hF);
        chk("rst_font", fndfont, 8'hFF);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check_scan("s1a");
        check_scan("s1b");

        // 2. 1234
        value = 14'd1234;
        exp_q.push_back(1234);
        run_conversion(0, "s2");
        check_scan("s2");

        // 3. 9999, then 5 two cycles later
        value = 14'd9999;
        exp_q.push_back(9999);
        @(negedge clk);
        @(negedge clk);
        value = 14'd5;
        exp_q.push_back(5);
        run_conversion(1, "s3a");
        run_conversion(0, "s3b");
        check_scan("s3");

        // 4. overflow
        value = 14'd10000;
        exp_q.push_back(10000);
        run_conversion(0, "s4");
        check_scan("s4");

        // 5. enable toggle mid-scan; check_scan left us at ones slot, offset 0
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("s5_off_digit", digit, 4'hF);
        chk("s5_off_font", fndfont, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        chk("s5_off2_digit", digit, 4'hF);
        en = 1'b1;
        @(negedge clk);
        chk("s5_on_digit", digit, 4'b1101);
        chk("s5_on_font", fndfont, 8'hBF);
        repeat (3) @(negedge clk);
        chk("s5_next_digit", digit, 4'b1011);
        $display("tb: s5 resume digit=%b font=%h", digit, fndfont);

        // 6. reset during conversion of 4321
        value = 14'd4321;
        exp_q.push_back(4321);
        guard = 0;
        while (busy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("s6_busy_rise", (guard < 50), 1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_async_busy", busy, 0);
        chk("s6_async_digit", digit, 4'hF);
        chk("s6_async_font", fndfont, 8'hFF);
        $display("tb: s6 async reset busy=%b digit=%b font=%h", busy, digit, fndfont);
        shown = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_conversion(0, "s6");
        check_scan("s6");

        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
